// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t     : memory-handshake FSM state (IDLE / MEM_WAIT)
//   FWD_*       : EX operand-mux forwarding selects
//   REG_ZERO    : hard-wired zero register, never a real dependency
//   src_hit()   : "this source reads the register that this writer will write"
package pipe_ctrl_pkg;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE     = 1'b0;
   localparam state_t ST_MEM_WAIT = 1'b1;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic src_hit(input logic       rd,
                                    input logic [4:0] src,
                                    input logic       wr,
                                    input logic [4:0] dst);
      return rd && wr && (dst != REG_ZERO) && (src == dst);
   endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding select for one EX operand.
//   src_i                          : EX source register number
//   mem_wn_i / mem_regwrite_i      : EX/MEM destination and write enable
//   wb_wn_i  / wb_regwrite_i       : MEM/WB destination and write enable
//   fwd_o                          : FWD_MEM, FWD_WB or FWD_RF
// EX/MEM is the younger producer, so it wins over MEM/WB.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] src_i,
   input  logic [4:0] mem_wn_i,
   input  logic       mem_regwrite_i,
   input  logic [4:0] wb_wn_i,
   input  logic       wb_regwrite_i,
   output logic [1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_RF;
      if (src_hit(1'b1, src_i, mem_regwrite_i, mem_wn_i)) begin
         fwd_o = FWD_MEM;
      end else if (src_hit(1'b1, src_i, wb_regwrite_i, wb_wn_i)) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Inputs : ID/EX/MEM/WB register numbers and control bits, branch-taken from EX,
//          dmem_ack_i from data memory.
// Outputs: per-register load enables, IF/ID flush, ID/EX and MEM/WB bubbles,
//          dmem_req_o, EX forwarding selects, sticky mem_err_o, and saturating
//          stall/flush performance counters.
// Build option: define FORWARDING_EN to enable operand forwarding. Without it the
// forwarding selects stay at the register file and every RAW dependency on an
// in-flight EX or MEM writer stalls ID instead.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_use_rs_i,
   input  logic             id_use_rt_i,
   input  logic [4:0]       ex_rs_i,
   input  logic [4:0]       ex_rt_i,
   input  logic [4:0]       ex_wn_i,
   input  logic             ex_regwrite_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       mem_wn_i,
   input  logic             mem_regwrite_i,
   input  logic             mem_access_i,
   input  logic [4:0]       wb_wn_i,
   input  logic             wb_regwrite_i,
   input  logic             ex_branch_taken_i,
   input  logic             dmem_ack_i,
   output logic             dmem_req_o,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             idex_en_o,
   output logic             exmem_en_o,
   output logic             memwb_en_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             memwb_bubble_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               mem_err_q, mem_err_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               freeze;
   logic               hazard;
   logic [1:0]         fwd_a_raw, fwd_b_raw;

   // Some inputs are only consumed in one build flavour.
   logic unused_inputs;
   assign unused_inputs = ^{ex_rs_i, ex_rt_i, wb_wn_i, wb_regwrite_i, ex_regwrite_i};

`ifdef FORWARDING_EN
   pipe_fwd_unit u_fwd_a (
      .src_i          (ex_rs_i),
      .mem_wn_i       (mem_wn_i),
      .mem_regwrite_i (mem_regwrite_i),
      .wb_wn_i        (wb_wn_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .fwd_o          (fwd_a_raw)
   );

   pipe_fwd_unit u_fwd_b (
      .src_i          (ex_rt_i),
      .mem_wn_i       (mem_wn_i),
      .mem_regwrite_i (mem_regwrite_i),
      .wb_wn_i        (wb_wn_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .fwd_o          (fwd_b_raw)
   );

   // Only a load in EX cannot be forwarded in time.
   assign hazard = src_hit(id_use_rs_i, id_rs_i, ex_memread_i, ex_wn_i) |
                   src_hit(id_use_rt_i, id_rt_i, ex_memread_i, ex_wn_i);
`else
   assign fwd_a_raw = FWD_RF;
   assign fwd_b_raw = FWD_RF;

   // No bypass paths: wait until the producer reaches WB (regfile writes first half).
   assign hazard =
      src_hit(id_use_rs_i, id_rs_i, ex_regwrite_i | ex_memread_i, ex_wn_i) |
      src_hit(id_use_rt_i, id_rt_i, ex_regwrite_i | ex_memread_i, ex_wn_i) |
      src_hit(id_use_rs_i, id_rs_i, mem_regwrite_i, mem_wn_i) |
      src_hit(id_use_rt_i, id_rt_i, mem_regwrite_i, mem_wn_i);
`endif

   // Memory handshake. The first cycle of a multi-cycle access is already frozen
   // in IDLE so the MEM instruction never leaves without its data.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      freeze    = 1'b0;
      if (state_q == ST_IDLE) begin
         if (mem_access_i && !dmem_ack_i) begin
            freeze  = 1'b1;
            state_d = ST_MEM_WAIT;
            wait_d  = '0;
         end
      end else begin
         if (dmem_ack_i) begin
            state_d = ST_IDLE;
         end else if (wait_q == WAIT_LAST) begin
            // Abort: release as if acked, load data is undefined.
            state_d   = ST_IDLE;
            mem_err_d = 1'b1;
         end else begin
            freeze = 1'b1;
            wait_d = wait_q + WAIT_W'(1);
         end
      end
   end

   // Priority: memory freeze > branch flush > data hazard stall > normal.
   always_comb begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_en_o     = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
      dmem_req_o     = 1'b0;
      fwd_a_o        = FWD_RF;
      fwd_b_o        = FWD_RF;
      if (rst_ni) begin
         dmem_req_o     = mem_access_i | (state_q == ST_MEM_WAIT);
         fwd_a_o        = fwd_a_raw;
         fwd_b_o        = fwd_b_raw;
         ifid_flush_o   = 1'b0;
         idex_bubble_o  = 1'b0;
         memwb_bubble_o = 1'b0;
         if (freeze) begin
            // WB keeps clocking a bubble so the frozen instruction is not retired twice.
            memwb_en_o     = 1'b1;
            memwb_bubble_o = 1'b1;
         end else begin
            idex_en_o  = 1'b1;
            exmem_en_o = 1'b1;
            memwb_en_o = 1'b1;
            if (ex_branch_taken_i) begin
               pc_en_o       = 1'b1;
               ifid_en_o     = 1'b1;
               ifid_flush_o  = 1'b1;
               idex_bubble_o = 1'b1;
            end else if (hazard) begin
               idex_bubble_o = 1'b1;
            end else begin
               pc_en_o   = 1'b1;
               ifid_en_o = 1'b1;
            end
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush_o && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_err_o   = mem_err_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
